// File: rtl/dcache_mem_controller.sv
// Arbitrates dcache controller-side read/write requests onto NUM_CHANNELS memory channels,
// one outstanding request per channel, relaying each memory response back to its consumer.
module dcache_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } ch_state_e;

  ch_state_e                               state_q [NUM_CHANNELS];
  ch_state_e                               state_d [NUM_CHANNELS];
  logic [CW-1:0]                           cons_q  [NUM_CHANNELS];
  logic [CW-1:0]                           cons_d  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
  logic [CW-1:0]                           rr_ptr, rr_ptr_d;

  logic [NUM_CONSUMERS-1:0]                consumer_read_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_d;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready_d;
  logic [NUM_CHANNELS-1:0]                 mem_read_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_d;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        cons_q[ch]  <= '0;
      end
      claim_q              <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      state_q              <= state_d;
      cons_q               <= cons_d;
      claim_q              <= claim_d;
      rr_ptr               <= rr_ptr_d;
      consumer_read_ready  <= consumer_read_ready_d;
      consumer_read_data   <= consumer_read_data_d;
      consumer_write_ready <= consumer_write_ready_d;
      mem_read_valid       <= mem_read_valid_d;
      mem_read_address     <= mem_read_address_d;
      mem_write_valid      <= mem_write_valid_d;
      mem_write_address    <= mem_write_address_d;
      mem_write_data       <= mem_write_data_d;
    end
  end

  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [CW-1:0]            sel;
    logic [CW-1:0]            idx;
    logic [CW-1:0]            c;

    state_d                = state_q;
    cons_d                 = cons_q;
    claim_d                = claim_q;
    rr_ptr_d               = rr_ptr;
    consumer_read_ready_d  = consumer_read_ready;
    consumer_read_data_d   = consumer_read_data;
    consumer_write_ready_d = consumer_write_ready;
    mem_read_valid_d       = mem_read_valid;
    mem_read_address_d     = mem_read_address;
    mem_write_valid_d      = mem_write_valid;
    mem_write_address_d    = mem_write_address;
    mem_write_data_d       = mem_write_data;
    // Registered claims plus claims made by lower-index channels this cycle; releases
    // only take effect next cycle, so a freed consumer/channel is never re-granted same-edge.
    taken = claim_q;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    c     = '0;

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      c = cons_q[ch];
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          sel   = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = CW'((int'(rr_ptr) + k) % NUM_CONSUMERS);
            if (!found && !taken[idx] &&
                (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          if (found) begin
            taken[sel]   = 1'b1;
            claim_d[sel] = 1'b1;
            cons_d[ch]   = sel;
            rr_ptr_d     = CW'((int'(sel) + 1) % NUM_CONSUMERS);
            if (consumer_read_valid[sel]) begin
              state_d[ch]            = READ_WAIT;
              mem_read_valid_d[ch]   = 1'b1;
              mem_read_address_d[ch] = consumer_read_address[sel];
            end else begin
              state_d[ch]             = WRITE_WAIT;
              mem_write_valid_d[ch]   = 1'b1;
              mem_write_address_d[ch] = consumer_write_address[sel];
              mem_write_data_d[ch]    = consumer_write_data[sel];
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[ch]) begin
            state_d[ch]             = READ_RELAY;
            mem_read_valid_d[ch]    = 1'b0;
            consumer_read_ready_d[c] = 1'b1;
            consumer_read_data_d[c]  = mem_read_data[ch];
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready[ch]) begin
            state_d[ch]               = WRITE_RELAY;
            mem_write_valid_d[ch]     = 1'b0;
            consumer_write_ready_d[c] = 1'b1;
          end
        end
        READ_RELAY: begin
          if (!consumer_read_valid[c]) begin
            state_d[ch]              = IDLE;
            consumer_read_ready_d[c] = 1'b0;
            claim_d[c]               = 1'b0;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[c]) begin
            state_d[ch]               = IDLE;
            consumer_write_ready_d[c] = 1'b0;
            claim_d[c]                = 1'b0;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  // A consumer must hold its request while the memory access is in flight.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_proto
    a_read_held: assert property (@(posedge clk) disable iff (!reset)
      (state_q[g] == READ_WAIT) |-> consumer_read_valid[cons_q[g]]);
    a_write_held: assert property (@(posedge clk) disable iff (!reset)
      (state_q[g] == WRITE_WAIT) |-> consumer_write_valid[cons_q[g]]);
  end

endmodule

// File: tb/tb_dcache_mem_controller.sv
// Scoreboard bench for dcache_mem_controller: 8 consumers, 2 channels, behavioural memory responder.
module tb_dcache_mem_controller;
  localparam int NC  = 8;
  localparam int NCH = 2;
  localparam int AB  = 8;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]           consumer_read_valid;
  logic [NC-1:0][AB-1:0]   consumer_read_address;
  logic [NC-1:0]           consumer_read_ready;
  logic [NC-1:0][DB-1:0]   consumer_read_data;
  logic [NC-1:0]           consumer_write_valid;
  logic [NC-1:0][AB-1:0]   consumer_write_address;
  logic [NC-1:0][DB-1:0]   consumer_write_data;
  logic [NC-1:0]           consumer_write_ready;
  logic [NCH-1:0]          mem_read_valid;
  logic [NCH-1:0][AB-1:0]  mem_read_address;
  logic [NCH-1:0]          mem_read_ready;
  logic [NCH-1:0][DB-1:0]  mem_read_data;
  logic [NCH-1:0]          mem_write_valid;
  logic [NCH-1:0][AB-1:0]  mem_write_address;
  logic [NCH-1:0][DB-1:0]  mem_write_data;
  logic [NCH-1:0]          mem_write_ready;

  dcache_mem_controller #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_img [256];
  int          lat [NCH];
  int          rcnt [NCH];
  int          wcnt [NCH];
  logic        mem_sb_on;
  logic [7:0]  exp_memrd_q [NCH][$];
  logic [15:0] exp_memwr_q [NCH][$];
  logic [7:0]  exp_rd_q [NC][$];
  logic        exp_wr_q [NC][$];
  time         rd_done_t [NC];
  time         wr_done_t [NC];
  int          done_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with no expectation queued", name, act);
  endtask

  // Memory model: answers a request lat[ch] cycles after it appears, for one cycle.
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (!reset || !mem_read_valid[ch] || mem_read_ready[ch]) begin
        mem_read_ready[ch] = 1'b0;
        rcnt[ch] = 0;
      end else if (rcnt[ch] >= lat[ch]) begin
        mem_read_ready[ch] = 1'b1;
        mem_read_data[ch]  = mem_img[mem_read_address[ch]];
      end else begin
        rcnt[ch]++;
      end
      if (!reset || !mem_write_valid[ch] || mem_write_ready[ch]) begin
        mem_write_ready[ch] = 1'b0;
        wcnt[ch] = 0;
      end else if (wcnt[ch] >= lat[ch]) begin
        mem_write_ready[ch] = 1'b1;
        mem_img[mem_write_address[ch]] = mem_write_data[ch];
      end else begin
        wcnt[ch]++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a new request or response.
  logic [NCH-1:0] p_mrv = '0, p_mwv = '0;
  logic [NC-1:0]  p_crr = '0, p_cwr = '0;
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (mem_read_valid[ch] && !p_mrv[ch] && mem_sb_on) begin
        if (exp_memrd_q[ch].size() == 0) flag($sformatf("memrd_unexpected_ch%0d", ch), mem_read_address[ch]);
        else check($sformatf("memrd_addr_ch%0d", ch), mem_read_address[ch], exp_memrd_q[ch].pop_front());
      end
      if (mem_write_valid[ch] && !p_mwv[ch] && mem_sb_on) begin
        if (exp_memwr_q[ch].size() == 0) flag($sformatf("memwr_unexpected_ch%0d", ch), mem_write_address[ch]);
        else check($sformatf("memwr_addr_data_ch%0d", ch), {mem_write_address[ch], mem_write_data[ch]},
                   exp_memwr_q[ch].pop_front());
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (consumer_read_ready[c] && !p_crr[c]) begin
        if (exp_rd_q[c].size() == 0) flag($sformatf("rd_ready_unexpected_c%0d", c), consumer_read_data[c]);
        else check($sformatf("rd_data_c%0d", c), consumer_read_data[c], exp_rd_q[c].pop_front());
      end
      if (consumer_write_ready[c] && !p_cwr[c]) begin
        if (exp_wr_q[c].size() == 0) flag($sformatf("wr_ready_unexpected_c%0d", c), consumer_write_ready);
        else void'(exp_wr_q[c].pop_front());
      end
    end
    p_mrv = mem_read_valid;
    p_mwv = mem_write_valid;
    p_crr = consumer_read_ready;
    p_cwr = consumer_write_ready;
  end

  task automatic cons_read(input int c, input logic [7:0] a, input logic [7:0] d,
                           input int ch, input int hold);
    int n;
    exp_rd_q[c].push_back(d);
    if (ch >= 0) exp_memrd_q[ch].push_back(a);
    @(negedge clk);
    consumer_read_valid[c]   = 1'b1;
    consumer_read_address[c] = a;
    n = 0;
    while (!consumer_read_ready[c] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!consumer_read_ready[c]) flag($sformatf("rd_timeout_c%0d", c), n);
    rd_done_t[c] = $time;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rd_ready_held", consumer_read_ready[c], 1);
      check("rd_data_held", consumer_read_data[c], d);
    end
    consumer_read_valid[c] = 1'b0;
    @(negedge clk);
    check($sformatf("rd_ready_fall_c%0d", c), consumer_read_ready[c], 0);
    @(negedge clk);
  endtask

  task automatic cons_write(input int c, input logic [7:0] a, input logic [7:0] d,
                            input int ch, input int hold);
    int n;
    exp_wr_q[c].push_back(1'b1);
    if (ch >= 0) exp_memwr_q[ch].push_back({a, d});
    @(negedge clk);
    consumer_write_valid[c]   = 1'b1;
    consumer_write_address[c] = a;
    consumer_write_data[c]    = d;
    n = 0;
    while (!consumer_write_ready[c] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!consumer_write_ready[c]) flag($sformatf("wr_timeout_c%0d", c), n);
    wr_done_t[c] = $time;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("wr_ready_held", consumer_write_ready[c], 1);
    end
    consumer_write_valid[c] = 1'b0;
    @(negedge clk);
    check($sformatf("wr_ready_fall_c%0d", c), consumer_write_ready[c], 0);
    @(negedge clk);
  endtask

  task automatic cons_loop(input int c);
    int idx;
    logic [7:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 8'(c * 16 + i);
      cons_read(c, a, ~a, -1, 0);
      idx = done_cnt;
      done_cnt++;
      check($sformatf("fair_round_c%0d", c), idx / 8, i);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    mem_read_ready         = '0;
    mem_read_data          = '0;
    mem_write_ready        = '0;
    mem_sb_on              = 1'b1;
    done_cnt               = 0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'(255 - i);
    for (int ch = 0; ch < NCH; ch++) begin
      lat[ch] = 0;
      rcnt[ch] = 0;
      wcnt[ch] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_valids", {mem_read_valid, mem_write_valid}, 0);
    check("rst_cons_readys", {consumer_read_ready, consumer_write_ready}, 0);
    check("rst_mem_addr_data", {mem_read_address, mem_write_address, mem_write_data}, 0);
    check("rst_cons_data", consumer_read_data, 0);
    reset = 1'b1;

    // 1: asynchronous reset while a read is outstanding
    lat[0] = 60;
    exp_memrd_q[0].push_back(8'h33);
    @(negedge clk);
    consumer_read_valid[6]   = 1'b1;
    consumer_read_address[6] = 8'h33;
    n = 0;
    while (!mem_read_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_req_issued", mem_read_valid, 2'b01);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t1_async_mem_valid", {mem_read_valid, mem_write_valid}, 0);
    check("t1_async_mem_addr", mem_read_address, 0);
    check("t1_async_cons_ready", {consumer_read_ready, consumer_write_ready}, 0);
    consumer_read_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    lat[0] = 0;
    repeat (4) @(negedge clk);
    check("t1_no_stale_req", {mem_read_valid, mem_write_valid}, 0);
    check("t1_no_stale_ready", consumer_read_ready, 0);

    // 2: c3 read 0x42 -> 0xA5, held for 3 cycles after ready
    mem_img[8'h42] = 8'hA5;
    cons_read(3, 8'h42, 8'hA5, 0, 3);
    check("t2_data_kept", consumer_read_data[3], 8'hA5);

    // 3: c1 write 0x10 <= 0x7E
    cons_write(1, 8'h10, 8'h7E, 0, 1);
    check("t3_mem_written", mem_img[8'h10], 8'h7E);

    // 4: c0,c2,c5 together from rr_ptr 0; ch1 frees first and takes c5
    reset_pulse();
    lat[0] = 3;
    lat[1] = 0;
    mem_img[8'h20] = 8'hC0;
    mem_img[8'h22] = 8'hC2;
    mem_img[8'h25] = 8'hC5;
    exp_memrd_q[0].push_back(8'h20);
    exp_memrd_q[1].push_back(8'h22);
    exp_memrd_q[1].push_back(8'h25);
    fork
      cons_read(0, 8'h20, 8'hC0, -1, 0);
      cons_read(2, 8'h22, 8'hC2, -1, 0);
      cons_read(5, 8'h25, 8'hC5, -1, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t4_rr_ptr", dut.rr_ptr, 3);
        check("t4_both_channels_busy", mem_read_valid, 2'b11);
      end
    join
    check("t4_c5_after_c2", rd_done_t[5] > rd_done_t[2], 1);

    // 5: c4 read and write together -> read first, write on the next grant
    lat[0] = 0;
    lat[1] = 0;
    mem_img[8'h44] = 8'h5C;
    exp_memrd_q[0].push_back(8'h44);
    exp_memwr_q[0].push_back({8'h54, 8'h3C});
    fork
      cons_read(4, 8'h44, 8'h5C, -1, 0);
      cons_write(4, 8'h54, 8'h3C, -1, 0);
    join
    check("t5_read_before_write", wr_done_t[4] > rd_done_t[4], 1);
    check("t5_mem_written", mem_img[8'h54], 8'h3C);

    // 6: all consumers re-requesting; every block of 8 completions covers each consumer once
    mem_sb_on = 1'b0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'(255 - i);
    fork
      cons_loop(0);
      cons_loop(1);
      cons_loop(2);
      cons_loop(3);
      cons_loop(4);
      cons_loop(5);
      cons_loop(6);
      cons_loop(7);
    join
    check("t6_total_completions", done_cnt, 24);

    repeat (3) @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("end_rd_queue_empty_c%0d", c), exp_rd_q[c].size(), 0);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("end_memrd_queue_empty_ch%0d", ch), exp_memrd_q[ch].size(), 0);
      check($sformatf("end_memwr_queue_empty_ch%0d", ch), exp_memwr_q[ch].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
